// File: rtl/opb_register_simulink2ppc_pkg.sv
// Shared definitions for the Simulink-to-PPC OPB register block:
// register offsets, STATUS/CTRL bit positions, handshake states and
// the STATUS packing helper.
package opb_register_simulink2ppc_pkg;

    localparam logic [31:0] REG_OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] REG_OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] REG_OFF_CTRL   = 32'h0000_0008;

    localparam int STATUS_NEW_BIT  = 16;
    localparam int STATUS_OVR_BIT  = 17;
    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } opb_state_e;

    // Assemble the STATUS word; bits above the overrun flag read as zero.
    function automatic logic [31:0] pack_status(input logic [15:0] count,
                                                input logic        new_data,
                                                input logic        overrun);
        logic [31:0] word;
        word                 = 32'h0000_0000;
        word[15:0]           = count;
        word[STATUS_NEW_BIT] = new_data;
        word[STATUS_OVR_BIT] = overrun;
        return word;
    endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side signal bundle. Vectors keep the bus's big-endian
// numbering: bit 0 is the MSB.
interface opb_register_simulink2ppc_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_s2p_capture.sv
// Fabric-side capture of user_data_in with capture counter, new-data flag
// and sticky overrun flag. A clear dominates everything except the DATA
// word itself, which still captures.
module opb_s2p_capture
    import opb_register_simulink2ppc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    input  logic        freeze,
    input  logic        clear,
    input  logic        data_read,
    output logic [31:0] data_out,
    output logic [31:0] status_out
);

    logic [31:0] data_r;
    logic [15:0] count_r;
    logic        new_r;
    logic        ovr_r;
    logic        capture_s;

    assign capture_s  = data_valid & ~freeze;
    assign data_out   = data_r;
    assign status_out = pack_status(count_r, new_r, ovr_r);

    // Capture register, counter and flags; a coincident DATA read keeps new-data set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= 32'h0000_0000;
            count_r <= 16'h0000;
            new_r   <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (capture_s) begin
                data_r <= data_in;
            end
            if (clear) begin
                count_r <= 16'h0000;
                new_r   <= 1'b0;
                ovr_r   <= 1'b0;
            end else if (capture_s) begin
                count_r <= count_r + 16'd1;
                new_r   <= 1'b1;
                if (new_r && !data_read) begin
                    ovr_r <= 1'b1;
                end
            end else if (data_read) begin
                new_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a captured fabric word: DATA (RO), STATUS (RO) and
// CTRL (freeze / self-clearing clear). One ack per select assertion; the
// read word and all side effects are taken on the IDLE->ACK edge.
module opb_register_simulink2ppc
    import opb_register_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst_n,
    opb_register_simulink2ppc_if.slave   bus,
    input  logic [31:0]                  user_data_in,
    input  logic                         user_data_valid
);

    localparam logic [C_OPB_AWIDTH-1:0] WIN_SPAN = C_OPB_AWIDTH'(C_HIGHADDR - C_BASEADDR);

    opb_state_e                state_r;
    opb_state_e                state_nxt_s;
    logic [C_OPB_AWIDTH-1:0]   addr_s;
    logic [C_OPB_AWIDTH-1:0]   offset_s;
    logic [C_OPB_DWIDTH-1:0]   wdata_s;
    logic [C_OPB_DWIDTH-1:0]   rd_mux_s;
    logic [C_OPB_DWIDTH-1:0]   sl_dbus_r;
    logic [31:0]               data_s;
    logic [31:0]               status_s;
    logic                      xfer_ack_r;
    logic                      freeze_r;
    logic                      in_window_s;
    logic                      start_s;
    logic                      ctrl_wr_s;
    logic                      clear_s;
    logic                      data_rd_s;
    logic                      unused_bits_s;

    // Whole-vector assignment maps big-endian bus bit 0 onto register bit 31.
    assign addr_s      = bus.OPB_ABus;
    assign wdata_s     = bus.OPB_DBus;
    assign offset_s    = addr_s - C_BASEADDR[C_OPB_AWIDTH-1:0];
    assign in_window_s = (offset_s <= WIN_SPAN);

    assign bus.Sl_DBus    = sl_dbus_r;
    assign bus.Sl_xferAck = xfer_ack_r;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

    assign unused_bits_s = ^{bus.OPB_seqAddr, bus.OPB_BE[0:2], wdata_s[C_OPB_DWIDTH-1:2]};

    // Address decode, transfer start strobes and read-data selection.
    always_comb begin
        start_s   = 1'b0;
        ctrl_wr_s = 1'b0;
        clear_s   = 1'b0;
        data_rd_s = 1'b0;
        rd_mux_s  = {C_OPB_DWIDTH{1'b0}};
        if ((state_r == ST_IDLE) && bus.OPB_select && in_window_s) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        // BE[3] is the lane carrying register bits [7:0].
        if (start_s && !bus.OPB_RNW && (offset_s == REG_OFF_CTRL) && bus.OPB_BE[3]) begin
            ctrl_wr_s = 1'b1;
            clear_s   = wdata_s[CTRL_CLEAR_BIT];
        end else begin
            ctrl_wr_s = 1'b0;
            clear_s   = 1'b0;
        end
        if (start_s && bus.OPB_RNW && (offset_s == REG_OFF_DATA)) begin
            data_rd_s = 1'b1;
        end else begin
            data_rd_s = 1'b0;
        end
        case (offset_s)
            REG_OFF_DATA:   rd_mux_s = data_s;
            REG_OFF_STATUS: rd_mux_s = status_s;
            REG_OFF_CTRL:   rd_mux_s = {{(C_OPB_DWIDTH-1){1'b0}}, freeze_r};
            default:        rd_mux_s = {C_OPB_DWIDTH{1'b0}};
        endcase
    end

    // Handshake next-state: one ACK cycle, then hold in WAIT until select drops.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK:  state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (!bus.OPB_select) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered bus outputs: ack and read data only during the ACK cycle.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            xfer_ack_r <= 1'b0;
            sl_dbus_r  <= {C_OPB_DWIDTH{1'b0}};
        end else begin
            xfer_ack_r <= start_s;
            sl_dbus_r  <= start_s ? rd_mux_s : {C_OPB_DWIDTH{1'b0}};
        end
    end

    // CTRL freeze bit; the clear bit is a one-shot strobe and is not stored.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            freeze_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            freeze_r <= wdata_s[CTRL_FREEZE_BIT];
        end
    end

    opb_s2p_capture u_capture (
        .clk        (OPB_Clk),
        .rst_n      (OPB_Rst_n),
        .data_in    (user_data_in),
        .data_valid (user_data_valid),
        .freeze     (freeze_r),
        .clear      (clear_s),
        .data_read  (data_rd_s),
        .data_out   (data_s),
        .status_out (status_s)
    );

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Self-checking bench: directed scenarios plus randomized bus/capture
// traffic compared against a behavioural register model.
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] HIGH = 32'h4000_00FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] user_data_in = 32'h0;
    logic        user_data_valid = 1'b0;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_if bus();

    opb_register_simulink2ppc #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst_n       (rst_n),
        .bus             (bus.slave),
        .user_data_in    (user_data_in),
        .user_data_valid (user_data_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_data;
    int          m_count;
    bit          m_new, m_ovr, m_freeze;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dbus_to_word(input logic [0:31] b);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[31-i] = b[i];
        return w;
    endfunction

    function automatic logic [0:31] word_to_dbus(input logic [31:0] w);
        logic [0:31] b;
        for (int i = 0; i < 32; i++) b[i] = w[31-i];
        return b;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] off);
        if (off == 32'h0) return m_data;
        if (off == 32'h4) return 32'(m_ovr) * 32'd131072 + 32'(m_new) * 32'd65536 + 32'(m_count);
        if (off == 32'h8) return 32'(m_freeze);
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_data = 32'h0; m_count = 0; m_new = 0; m_ovr = 0; m_freeze = 0;
    endtask

    // One clock edge of the register rules as seen by software.
    task automatic model_edge(input bit v, input logic [31:0] w, input bit rd_data,
                              input bit ctrl_wr, input logic [31:0] wdata);
        bit cap;
        bit clr;
        cap = v && !m_freeze;
        clr = ctrl_wr && wdata[1];
        if (cap) m_data = w;
        if (clr) begin
            m_count = 0; m_new = 0; m_ovr = 0;
        end else if (cap) begin
            if (m_new && !rd_data) m_ovr = 1;
            m_count = (m_count + 1) % 65536;
            m_new = 1;
        end else if (rd_data) begin
            m_new = 0;
        end
        if (ctrl_wr) m_freeze = wdata[0];
    endtask

    task automatic bus_idle();
        bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b1; bus.OPB_ABus = '0;
        bus.OPB_BE = 4'b0000; bus.OPB_DBus = '0; bus.OPB_seqAddr = 1'b0;
    endtask

    task automatic cap_cycle(input logic [31:0] w);
        @(negedge clk);
        user_data_in = w; user_data_valid = 1'b1;
        @(posedge clk); #1;
        model_edge(1'b1, w, 1'b0, 1'b0, 32'h0);
        user_data_valid = 1'b0;
    endtask

    // Full OPB transfer; checks latency, read data, and that only one ack appears.
    task automatic bus_xfer(input string tag, input logic [31:0] off, input bit rnw,
                            input logic [31:0] wdata, input logic [0:3] be,
                            input bit v, input logic [31:0] w, output logic [31:0] rdata);
        logic [31:0] exp;
        int lat;
        bit seen;
        rdata = 32'h0; lat = 0; seen = 0;
        @(negedge clk);
        bus.OPB_ABus = BASE + off; bus.OPB_RNW = rnw; bus.OPB_BE = be;
        bus.OPB_DBus = word_to_dbus(wdata); bus.OPB_select = 1'b1;
        bus.OPB_seqAddr = 1'($urandom_range(0, 1));
        user_data_in = w; user_data_valid = v;
        exp = exp_read(off);
        for (int k = 1; k <= 4 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                model_edge(v, w, rnw && (off == 32'h0), !rnw && (off == 32'h8) && be[3], wdata);
                user_data_valid = 1'b0;
            end
            if (bus.Sl_xferAck) begin
                seen = 1; lat = k; rdata = dbus_to_word(bus.Sl_DBus);
            end
        end
        check_value({tag, "_lat"}, lat, 32'd1);
        if (rnw) check_value(tag, rdata, exp);
        @(negedge clk);
        bus.OPB_select = 1'b0;
        @(posedge clk); #1;
        check_value({tag, "_after"}, {bus.Sl_xferAck, dbus_to_word(bus.Sl_DBus)} != 33'h0, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] off, output logic [31:0] d);
        bus_xfer(tag, off, 1'b1, 32'h0, 4'b1111, 1'b0, 32'h0, d);
    endtask

    task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d, input logic [0:3] be);
        logic [31:0] dummy;
        bus_xfer(tag, off, 1'b0, d, be, 1'b0, 32'h0, dummy);
    endtask

    // Hold select for n cycles at addr; returns number of acks seen.
    task automatic hold_select(input logic [31:0] addr, input bit rnw, input int n, output int acks);
        acks = 0;
        @(negedge clk);
        bus.OPB_ABus = addr; bus.OPB_RNW = rnw; bus.OPB_BE = 4'b1111;
        bus.OPB_DBus = word_to_dbus(32'h0000_0003); bus.OPB_select = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) acks++;
        end
        @(negedge clk);
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [31:0] r;
    int acks;
    logic [31:0] offs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'hFC};

    initial begin
        bus_idle();
        model_reset();
        repeat (3) @(negedge clk);
        check_value("rst_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        check_value("rst_dbus", dbus_to_word(bus.Sl_DBus), 32'h0);
        rst_n = 1'b1;
        rd("rst_data", 32'h0, r);
        rd("rst_status", 32'h4, r);
        rd("rst_ctrl", 32'h8, r);

        // Capture then read
        cap_cycle(32'hDEADBEEF);
        rd("cap_data", 32'h0, r);
        check_value("cap_data_const", r, 32'hDEADBEEF);
        rd("cap_status", 32'h4, r);
        check_value("cap_status_const", r, 32'h0000_0001);

        // Two captures without read
        wr("clr1", 32'h8, 32'h2, 4'b1111);
        cap_cycle(32'h0000_0001);
        cap_cycle(32'h0000_0002);
        rd("ovr_status", 32'h4, r);
        check_value("ovr_status_const", r, 32'h0003_0002);

        // Freeze, then clear
        wr("freeze", 32'h8, 32'h1, 4'b1111);
        cap_cycle(32'h0000_1234);
        rd("frz_status", 32'h4, r);
        check_value("frz_status_const", r, 32'h0003_0002);
        rd("frz_data", 32'h0, r);
        check_value("frz_data_const", r, 32'h0000_0002);
        wr("clr2", 32'h8, 32'h2, 4'b1111);
        rd("clr_status", 32'h4, r);
        check_value("clr_status_const", r, 32'h0);

        // Byte enable gating on CTRL lane 0
        wr("be_off", 32'h8, 32'h3, 4'b1110);
        rd("be_ctrl", 32'h8, r);
        check_value("be_ctrl_const", r, 32'h0);

        // DATA read coincident with capture
        cap_cycle(32'h1111_1111);
        bus_xfer("race_data", 32'h0, 1'b1, 32'h0, 4'b1111, 1'b1, 32'hA5A5A5A5, r);
        check_value("race_data_const", r, 32'h1111_1111);
        rd("race_status", 32'h4, r);
        check_value("race_new", {31'd0, r[16]}, 32'd1);
        check_value("race_ovr", {31'd0, r[17]}, 32'd0);
        rd("race_data2", 32'h0, r);

        // Out-of-window selects get no response
        hold_select(BASE + 32'h100, 1'b0, 8, acks);
        check_value("oow_high_acks", acks, 32'd0);
        hold_select(BASE - 32'h4, 1'b1, 8, acks);
        check_value("oow_low_acks", acks, 32'd0);
        rd("oow_ctrl", 32'h8, r);

        // Long select: single ack
        hold_select(BASE + 32'h4, 1'b1, 5, acks);
        check_value("hold_acks", acks, 32'd1);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            int op;
            logic [31:0] rw;
            op = $urandom_range(0, 3);
            rw = $urandom;
            case (op)
                0: cap_cycle(rw);
                1: bus_xfer("rnd_rd", offs[$urandom_range(0, 5)], 1'b1, 32'h0, 4'b1111,
                            ($urandom_range(0, 3) == 0), rw, r);
                2: wr("rnd_ctrl", 32'h8, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)));
                default: wr("rnd_ign", offs[$urandom_range(0, 5)] & 32'hFFFF_FFF7 | 32'h0, rw, 4'b1111);
            endcase
        end
        rd("rnd_final_status", 32'h4, r);

        // Counter wrap
        wr("unfreeze", 32'h8, 32'h2, 4'b1111);
        for (int i = 0; i < 65536; i++) cap_cycle(32'hC0DE_0000 ^ 32'(i));
        rd("wrap_status", 32'h4, r);
        check_value("wrap_count", {16'h0, r[15:0]}, 32'h0);
        rd("wrap_data", 32'h0, r);
        check_value("wrap_data_const", r, 32'hC0DE_FFFF);

        // Reset during ACK
        cap_cycle(32'h5555_AAAA);
        wr("pre_rst_frz", 32'h8, 32'h1, 4'b1111);
        @(negedge clk);
        bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        @(posedge clk); #1;
        check_value("pre_rst_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("rst_mid_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        check_value("rst_mid_dbus", dbus_to_word(bus.Sl_DBus), 32'h0);
        model_reset();
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.Sl_xferAck) acks++;
        end
        check_value("post_rst_idle", acks, 32'd0);
        rd("post_rst_data", 32'h0, r);
        rd("post_rst_status", 32'h4, r);
        rd("post_rst_ctrl", 32'h8, r);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
